// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_pkg
//  Description : Shared types and default constants for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          DEF_PC_W      = 10;
    localparam int          LUT_IDX_W     = 4;
    localparam int          DEF_LUT_DEPTH = 16;
    localparam logic [8:0]  DEF_HALT_OP   = 9'h1FF;
    localparam logic [8:0]  DEF_NOP_INSTR = 9'h1C0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fetch_if
//  Description : Program handshake, LUT load, ROM and decoder signals of the
//                fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
);
    logic                 Start;
    logic                 lut_wr_en;
    logic [LUT_IDX_W-1:0] lut_wr_addr;
    logic [PC_W-1:0]      lut_wr_data;
    logic [8:0]           instr_rom_data;
    logic                 pc_jmp_en;
    logic                 pc_jmp_abs;
    logic [LUT_IDX_W-1:0] LutPointer;
    logic [PC_W-1:0]      prog_ctr;
    logic [8:0]           instr;
    logic                 instr_valid;
    logic                 Done;
    logic [15:0]          cycle_count;

    modport master (
        output Start, lut_wr_en, lut_wr_addr, lut_wr_data, instr_rom_data,
               pc_jmp_en, pc_jmp_abs, LutPointer,
        input  prog_ctr, instr, instr_valid, Done, cycle_count
    );

    modport slave (
        input  Start, lut_wr_en, lut_wr_addr, lut_wr_data, instr_rom_data,
               pc_jmp_en, pc_jmp_abs, LutPointer,
        output prog_ctr, instr, instr_valid, Done, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/jump_lut.sv
`default_nettype none
// ============================================================================
//  Module      : jump_lut
//  Description : Jump-target register file, synchronous write, asynchronous
//                read, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_lut #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 10
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              wr_en_i,
    input  wire logic [IDX_W-1:0]  wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic [IDX_W-1:0]  rd_addr_i,
    output logic      [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_i) begin
                mem_q[i] <= '0;
            end else if (wr_en_i && (wr_addr_i == IDX_W'(i))) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter, instruction fetch, LUT-resolved jumps,
//                Start/Done handshake and run-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int         PC_W      = DEF_PC_W,
    parameter int         LUT_DEPTH = DEF_LUT_DEPTH,
    parameter logic [8:0] HALT_OP   = DEF_HALT_OP,
    parameter logic [8:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  wire logic Clk,
    input  wire logic Reset,
    fetch_if.slave    bus
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PC_W-1:0] lut_rd;
    logic            run;
    logic            halt_instr;

    assign run        = (state_q == RUN);
    assign halt_instr = run && (bus.instr_rom_data == HALT_OP);

    // Loading is locked out while running so the LUT is stable during execution.
    jump_lut #(
        .DEPTH  (LUT_DEPTH),
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_jump_lut (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .wr_en_i   (bus.lut_wr_en && !run),
        .wr_addr_i (bus.lut_wr_addr),
        .wr_data_i (bus.lut_wr_data),
        .rd_addr_i (bus.LutPointer),
        .rd_data_o (lut_rd)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (halt_instr) begin
                    state_d = HALT;
                end else if (bus.pc_jmp_en) begin
                    // Relative offset is two's complement; the add wraps modulo 2^PC_W.
                    pc_d = bus.pc_jmp_abs ? lut_rd : pc_q + lut_rd;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr       = run ? bus.instr_rom_data : NOP_INSTR;
    assign bus.instr_valid = run;
    assign bus.Done        = (state_q == HALT);
    assign bus.cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] rom [1024];

    fetch_if #(.PC_W(10)) bus ();

    fetch_unit u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    assign bus.instr_rom_data = rom[bus.prog_ctr];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic lut_write(input logic [3:0] addr, input logic [9:0] data);
        bus.lut_wr_en   = 1'b1;
        bus.lut_wr_addr = addr;
        bus.lut_wr_data = data;
        step();
        bus.lut_wr_en   = 1'b0;
    endtask

    task automatic jump(input logic abs, input logic [3:0] ptr);
        bus.pc_jmp_en  = 1'b1;
        bus.pc_jmp_abs = abs;
        bus.LutPointer = ptr;
        step();
        bus.pc_jmp_en  = 1'b0;
        bus.pc_jmp_abs = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        for (int i = 0; i < 5; i++) rom[i] = 9'(9'h010 + i);
        rom[5] = 9'h1FF;
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.lut_wr_en = 1'b0;
        bus.lut_wr_addr = '0;
        bus.lut_wr_data = '0;
        bus.pc_jmp_en = 1'b0;
        bus.pc_jmp_abs = 1'b0;
        bus.LutPointer = '0;
        step();
        check_val("rst_pc", 32'(bus.prog_ctr), 0);
        check_val("rst_done", 32'(bus.Done), 0);
        check_val("rst_cnt", 32'(bus.cycle_count), 0);
        check_val("rst_valid", 32'(bus.instr_valid), 0);
        check_val("rst_instr", 32'(bus.instr), 32'h1C0);
        Reset = 1'b0;

        // Straight-line program halting at address 5
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check_val("run_pc0", 32'(bus.prog_ctr), 0);
        check_val("run_valid", 32'(bus.instr_valid), 1);
        check_val("run_instr0", 32'(bus.instr), 32'h010);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_val("seq_pc", 32'(bus.prog_ctr), 32'(k));
        end
        check_val("pre_halt_done", 32'(bus.Done), 0);
        check_val("pre_halt_cnt", 32'(bus.cycle_count), 5);
        step();
        check_val("halt_done", 32'(bus.Done), 1);
        check_val("halt_pc", 32'(bus.prog_ctr), 5);
        check_val("halt_cnt", 32'(bus.cycle_count), 6);
        check_val("halt_instr", 32'(bus.instr), 32'h1C0);
        check_val("halt_valid", 32'(bus.instr_valid), 0);
        step();
        check_val("halt_hold_cnt", 32'(bus.cycle_count), 6);

        // Jump program: 0,1,2 ->40 ->20 ->16 ->1020 ->1 ->100(HALT)
        rom[5] = 9'h000;
        rom[100] = 9'h1FF;
        lut_write(4'd3, 10'd40);
        lut_write(4'd2, 10'd20);
        lut_write(4'd7, 10'h3FC);
        lut_write(4'd4, 10'd1020);
        lut_write(4'd1, 10'd5);
        lut_write(4'd5, 10'd100);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check_val("rs_pc0", 32'(bus.prog_ctr), 0);
        check_val("rs_done_low", 32'(bus.Done), 0);
        check_val("rs_cnt0", 32'(bus.cycle_count), 0);
        step();
        step();
        check_val("pre_abs_pc", 32'(bus.prog_ctr), 2);
        jump(1'b1, 4'd3);
        check_val("abs_jump", 32'(bus.prog_ctr), 40);
        jump(1'b1, 4'd2);
        check_val("abs_jump20", 32'(bus.prog_ctr), 20);
        // Start and a LUT write while running must both be ignored
        bus.Start = 1'b1;
        bus.lut_wr_en = 1'b1;
        bus.lut_wr_addr = 4'd3;
        bus.lut_wr_data = 10'd7;
        jump(1'b0, 4'd7);
        bus.Start = 1'b0;
        bus.lut_wr_en = 1'b0;
        check_val("rel_neg", 32'(bus.prog_ctr), 16);
        jump(1'b1, 4'd4);
        check_val("abs_1020", 32'(bus.prog_ctr), 1020);
        jump(1'b0, 4'd1);
        check_val("rel_wrap", 32'(bus.prog_ctr), 1);
        jump(1'b1, 4'd5);
        check_val("abs_100", 32'(bus.prog_ctr), 100);
        jump(1'b1, 4'd3);
        check_val("halt_jmp_pc", 32'(bus.prog_ctr), 100);
        check_val("halt_jmp_done", 32'(bus.Done), 1);
        check_val("jmp_run_cnt", 32'(bus.cycle_count), 9);

        // Restart: the RUN-time write to lut[3] must not have landed
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check_val("rs2_pc0", 32'(bus.prog_ctr), 0);
        jump(1'b1, 4'd3);
        check_val("lut_wr_ignored", 32'(bus.prog_ctr), 40);

        // Fresh run to PC 12, then reset mid-run
        bus.Start = 1'b1;
        step();
        check_val("start_ignored", 32'(bus.prog_ctr), 41);
        bus.Start = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int k = 0; k < 12; k++) step();
        check_val("mid_pc12", 32'(bus.prog_ctr), 12);
        check_val("mid_cnt12", 32'(bus.cycle_count), 12);
        Reset = 1'b1;
        bus.Start = 1'b1;
        step();
        Reset = 1'b0;
        bus.Start = 1'b0;
        check_val("mid_rst_pc", 32'(bus.prog_ctr), 0);
        check_val("mid_rst_cnt", 32'(bus.cycle_count), 0);
        check_val("mid_rst_valid", 32'(bus.instr_valid), 0);
        check_val("mid_rst_done", 32'(bus.Done), 0);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        check_val("post_rst_pc1", 32'(bus.prog_ctr), 1);
        jump(1'b1, 4'd3);
        check_val("lut_cleared", 32'(bus.prog_ctr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
